// File: rtl/recon_writeback.sv
// Reconstruction write-back: clips pred+residual per lane and streams one MB into frame memory.
// Optional RECON_EDGE_SAVE_EN keeps the bottom row / right column of the MB for the next fetch.

module recon_clip #(
  parameter int RES_W = 9
) (
  input  logic [7:0]       pred_i,
  input  logic [RES_W-1:0] res_i,
  output logic [7:0]       pix_o
);
  localparam int SW = RES_W + 2;
  logic signed [SW-1:0] sum;

  // Wide enough that pred + residual can never wrap, so the sign bit is a true underflow flag.
  always_comb begin
    sum = $signed({{(SW-8){1'b0}}, pred_i}) + $signed({{2{res_i[RES_W-1]}}, res_i});
    if (sum[SW-1])          pix_o = 8'd0;
    else if (|sum[SW-2:8])  pix_o = 8'hff;
    else                    pix_o = sum[7:0];
  end
endmodule

module recon_writeback #(
  parameter int WIDTH     = 1280,
  parameter int LENGTH    = 720,
  parameter int MB_SIZE_W = 16,
  parameter int MB_SIZE_L = 16,
  parameter int RES_W     = 9,
  parameter int ADDR_W    = 20
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [31:0]                       mbnumber,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [MB_SIZE_W-1:0][7:0]         pred_row,
  input  logic [MB_SIZE_W-1:0][RES_W-1:0]   residual_row,
  output logic                              wr_en,
  output logic [ADDR_W-1:0]                 wr_addr,
  output logic [7:0]                        wr_data,
  output logic                              busy,
  output logic                              done
`ifdef RECON_EDGE_SAVE_EN
  ,
  output logic [MB_SIZE_W-1:0][7:0]         next_top,
  output logic [MB_SIZE_L-1:0][7:0]         next_left
`endif
);
  localparam int CW = (MB_SIZE_W > 1) ? $clog2(MB_SIZE_W) : 1;
  localparam int RW = (MB_SIZE_L > 1) ? $clog2(MB_SIZE_L) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  generate
    if (longint'(WIDTH) * longint'(LENGTH) > (longint'(1) << ADDR_W))
      $error("ADDR_W too small for WIDTH*LENGTH");
  endgenerate

  logic [1:0]                 state_q, state_d;
  logic [RW-1:0]              r_q, r_d;
  logic [CW-1:0]              c_q, c_d;
  logic [ADDR_W-1:0]          base_q, base_d;
  logic [MB_SIZE_W-1:0][7:0]  pix_q, pix_d;
  logic [MB_SIZE_W-1:0][7:0]  clip_row;
  logic                       row_take;
  logic                       last_c, last_r;

  genvar g;
  generate
    for (g = 0; g < MB_SIZE_W; g++) begin : g_lane
      recon_clip #(.RES_W(RES_W)) u_clip (
        .pred_i (pred_row[g]),
        .res_i  (residual_row[g]),
        .pix_o  (clip_row[g])
      );
    end
  endgenerate

  assign in_ready = (state_q == S_WAIT);
  assign row_take = in_ready & in_valid;
  assign wr_en    = (state_q == S_WRITE);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign last_c   = (c_q == CW'(MB_SIZE_W - 1));
  assign last_r   = (r_q == RW'(MB_SIZE_L - 1));
  assign wr_addr  = wr_en ? (base_q + ADDR_W'(c_q)) : '0;
  assign wr_data  = wr_en ? pix_q[c_q] : 8'd0;

  // base_q tracks the address of the MB's left pixel on the current row.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    base_d  = base_q;
    pix_d   = pix_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_WAIT;
        r_d     = '0;
        c_d     = '0;
        base_d  = ADDR_W'(mbnumber[31:16]) * ADDR_W'(WIDTH) + ADDR_W'(mbnumber[15:0]);
      end
      S_WAIT: if (row_take) begin
        state_d = S_WRITE;
        c_d     = '0;
        pix_d   = clip_row;
      end
      S_WRITE: begin
        c_d = c_q + 1'b1;
        if (last_c) begin
          c_d = '0;
          if (last_r) state_d = S_DONE;
          else begin
            state_d = S_WAIT;
            r_d     = r_q + 1'b1;
            base_d  = base_q + ADDR_W'(WIDTH);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      base_q  <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      base_q  <= base_d;
      pix_q   <= pix_d;
    end
  end

`ifdef RECON_EDGE_SAVE_EN
  logic [MB_SIZE_W-1:0][7:0] top_q;
  logic [MB_SIZE_L-1:0][7:0] left_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      top_q  <= {MB_SIZE_W{8'd128}};
      left_q <= {MB_SIZE_L{8'd128}};
    end else if (wr_en) begin
      if (last_r) top_q[c_q]  <= wr_data;
      if (last_c) left_q[r_q] <= wr_data;
    end
  end

  assign next_top  = top_q;
  assign next_left = left_q;
`endif

endmodule

// File: tb/tb_recon_writeback.sv
// Scoreboard bench for recon_writeback: 16x16 instance plus a 4x4 instance at the frame edge.
module tb_recon_writeback;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- 16x16 instance ----------------
  logic                reset = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [31:0]         mbnumber = '0;
  logic [15:0][7:0]    pred_row = '0;
  logic [15:0][8:0]    residual_row = '0;
  logic                in_ready, wr_en, busy, done;
  logic [19:0]         wr_addr;
  logic [7:0]          wr_data;
`ifdef RECON_EDGE_SAVE_EN
  logic [15:0][7:0]    next_top;
  logic [15:0][7:0]    next_left;
  logic [7:0]          exp_top [16];
  logic [7:0]          exp_left[16];
`endif

  recon_writeback dut (
    .clk(clk), .reset(reset), .start(start), .mbnumber(mbnumber),
    .in_valid(in_valid), .in_ready(in_ready), .pred_row(pred_row),
    .residual_row(residual_row), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done)
`ifdef RECON_EDGE_SAVE_EN
    , .next_top(next_top), .next_left(next_left)
`endif
  );

  // ---------------- 4x4 instance ----------------
  logic                reset4 = 1'b1, start4 = 1'b0, in_valid4 = 1'b0;
  logic [31:0]         mbnumber4 = '0;
  logic [3:0][7:0]     pred_row4 = '0;
  logic [3:0][8:0]     residual_row4 = '0;
  logic                in_ready4, wr_en4, busy4, done4;
  logic [19:0]         wr_addr4;
  logic [7:0]          wr_data4;
`ifdef RECON_EDGE_SAVE_EN
  logic [3:0][7:0]     next_top4;
  logic [3:0][7:0]     next_left4;
`endif

  recon_writeback #(.MB_SIZE_W(4), .MB_SIZE_L(4)) dut4 (
    .clk(clk), .reset(reset4), .start(start4), .mbnumber(mbnumber4),
    .in_valid(in_valid4), .in_ready(in_ready4), .pred_row(pred_row4),
    .residual_row(residual_row4), .wr_en(wr_en4), .wr_addr(wr_addr4),
    .wr_data(wr_data4), .busy(busy4), .done(done4)
`ifdef RECON_EDGE_SAVE_EN
    , .next_top(next_top4), .next_left(next_left4)
`endif
  );

  function automatic logic [7:0] clip_model(input int p, input int r);
    int s;
    s = p + r;
    if (s < 0)   return 8'd0;
    if (s > 255) return 8'd255;
    return 8'(s);
  endfunction

  // ---------------- monitors ----------------
  logic [27:0] q  [$];
  logic [27:0] q4 [$];
  int mb_wr = 0, done_cnt = 0, first_addr = 0, last_addr = 0;
  int mb_wr4 = 0, done_cnt4 = 0, first_addr4 = 0, last_addr4 = 0;

  always @(posedge clk) begin
    logic [27:0] e;
    #1;
    if (wr_en) begin
      if (q.size() == 0) chk("extra_wr", 1, 0);
      else begin
        e = q.pop_front();
        chk("wr", {wr_addr, wr_data}, e);
      end
      if (mb_wr == 0) first_addr = int'(wr_addr);
      last_addr = int'(wr_addr);
      mb_wr++;
    end
    if (done) done_cnt++;
  end

  always @(posedge clk) begin
    logic [27:0] e;
    #1;
    if (wr_en4) begin
      if (q4.size() == 0) chk("extra_wr4", 1, 0);
      else begin
        e = q4.pop_front();
        chk("wr4", {wr_addr4, wr_data4}, e);
      end
      if (mb_wr4 == 0) first_addr4 = int'(wr_addr4);
      last_addr4 = int'(wr_addr4);
      mb_wr4++;
    end
    if (done4) done_cnt4++;
  end

  // mode 0: flat 100; 1: clip corners; 2: random; 3: edge pattern
  task automatic build_row(input int mode, input int r, output int pv[16], output int rv[16]);
    for (int c = 0; c < 16; c++) begin
      case (mode)
        0: begin pv[c] = 100; rv[c] = 0; end
        1: case ((c + r) % 4)
             0: begin pv[c] = 250; rv[c] = 20;   end
             1: begin pv[c] = 5;   rv[c] = -30;  end
             2: begin pv[c] = 0;   rv[c] = -256; end
             default: begin pv[c] = 255; rv[c] = 255; end
           endcase
        2: begin pv[c] = int'($urandom_range(0, 255)); rv[c] = int'($urandom_range(0, 511)) - 256; end
        default: begin
          pv[c] = (c == 15) ? 200 : ((r == 15) ? c : 50);
          if (r == 15 && c == 15) pv[c] = 15;
          rv[c] = 0;
        end
      endcase
    end
  endtask

  task automatic send_mb(input int row, input int col, input int mode, input int abort_r);
    int pv[16], rv[16];
    int guard, d0;
    bit taken;
    logic [8:0] r9;
    logic [19:0] a;
    mb_wr = 0;
    d0 = done_cnt;
    @(negedge clk);
    mbnumber = {row[15:0], col[15:0]};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mbnumber = $urandom;
    chk("busy_after_start", busy, 1);
    for (int r = 0; r < 16; r++) begin
      build_row(mode, r, pv, rv);
      taken = 0;
      guard = 0;
      while (!taken && guard < 200) begin
        if (in_ready && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          for (int c = 0; c < 16; c++) begin
            r9 = 9'(rv[c]);
            pred_row[c] = 8'(pv[c]);
            residual_row[c] = r9;
            a = 20'((row + r) * 1280 + col + c);
            q.push_back({a, clip_model(pv[c], rv[c])});
`ifdef RECON_EDGE_SAVE_EN
            if (r == 15) exp_top[c] = clip_model(pv[c], rv[c]);
            if (c == 15) exp_left[r] = clip_model(pv[c], rv[c]);
`endif
          end
          taken = 1;
        end else if (in_ready) begin
          in_valid = 1'b0;
        end else begin
          in_valid = 1'($urandom_range(0, 1));
          for (int c = 0; c < 16; c++) begin
            pred_row[c] = 8'($urandom);
            residual_row[c] = 9'($urandom);
          end
        end
        if (mode == 2) begin
          start = 1'($urandom_range(0, 1));
          mbnumber = $urandom;
        end
        @(negedge clk);
        guard++;
      end
      start = 1'b0;
      if (!taken) chk("row_timeout", 0, 1);
      if (r == abort_r) begin
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_wr_en", wr_en, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        repeat (20) @(negedge clk);
        chk("abort_no_wr", wr_en, 0);
        chk("abort_no_done", done_cnt - d0, 0);
        return;
      end
    end
    in_valid = 1'b0;
    guard = 0;
    while (!done && guard < 100) begin @(negedge clk); guard++; end
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_pulse", done, 0);
    chk("done_once", done_cnt - d0, 1);
    chk("mb_writes", mb_wr, 256);
    chk("queue_empty", q.size(), 0);
  endtask

  initial begin
    int guard;
    int pv;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
`ifdef RECON_EDGE_SAVE_EN
    chk("rst_top0", next_top[0], 128);
    chk("rst_left15", next_left[15], 128);
`endif
    reset = 1'b0;
    reset4 = 1'b0;
    @(negedge clk);

    // abort mid-write of row 3, then a clean MB from r=0
    send_mb(16, 32, 0, 3);
    send_mb(16, 32, 0, -1);
    chk("first_addr", first_addr, 20512);
    chk("last_addr", last_addr, 39727);

    send_mb(0, 0, 1, -1);
    send_mb(48, 640, 2, -1);
    send_mb(704, 1264, 3, -1);
`ifdef RECON_EDGE_SAVE_EN
    for (int c = 0; c < 16; c++) chk("next_top", next_top[c], exp_top[c]);
    for (int r = 0; r < 16; r++) chk("next_left", next_left[r], exp_left[r]);
    repeat (5) @(negedge clk);
    chk("top_hold", next_top[3], exp_top[3]);
`endif

    // 4x4 at the right frame edge
    @(negedge clk);
    mbnumber4 = {16'd0, 16'd1276};
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int r = 0; r < 4; r++) begin
      guard = 0;
      while (!in_ready4 && guard < 50) begin @(negedge clk); guard++; end
      if (!in_ready4) chk("row4_timeout", 0, 1);
      in_valid4 = 1'b1;
      for (int c = 0; c < 4; c++) begin
        pv = 10 * r + c;
        pred_row4[c] = 8'(pv);
        residual_row4[c] = 9'(c - 2);
        q4.push_back({20'(r * 1280 + 1276 + c), clip_model(pv, c - 2)});
      end
      @(negedge clk);
      in_valid4 = 1'b0;
    end
    guard = 0;
    while (!done4 && guard < 50) begin @(negedge clk); guard++; end
    chk("done4_seen", done4, 1);
    @(negedge clk);
    chk("done4_once", done_cnt4, 1);
    chk("mb_wr4", mb_wr4, 16);
    chk("first4", first_addr4, 1276);
    chk("last4", last_addr4, 5119);
    chk("busy4_after", busy4, 0);
    chk("q4_empty", q4.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1);
  end
endmodule
